// File: rtl/fp_round_prep_pkg.sv
`default_nettype none
// fp_round_prep_pkg: state encoding, default widths and a small min helper shared by fp_round_prep.
package fp_round_prep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LSHIFT = 2'd1,
      ST_RSHIFT = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int DEF_IN_W  = 106;
   localparam int DEF_OUT_W = 53;
   localparam int DEF_EXP_W = 13;
   localparam int DEF_STEP  = 16;
   localparam int DEF_EMIN  = -1022;

   function automatic int unsigned min3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_norm_lzc.sv
`default_nettype none
// fp_norm_lzc: leading-zero counter over an IN_W vector; a zero input reports IN_W.
module fp_norm_lzc
   import fp_round_prep_pkg::*;
#(
   parameter int IN_W = DEF_IN_W
) (
   input  logic [IN_W-1:0]           value,
   output logic [$clog2(IN_W+1)-1:0] count
);

   localparam int CNT_W = $clog2(IN_W + 1);

   // Scanning upward lets the highest set bit win the last assignment.
   always_comb begin
      count = CNT_W'(IN_W);
      for (int i = 0; i < IN_W; i++) begin
         if (value[i]) count = CNT_W'(IN_W - 1 - i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/fp_round_prep.sv
`default_nettype none
// fp_round_prep: iterative normaliser producing {mantissa, round, sticky} for rounding.
// Optional kill input io_flush is built only when FP_ROUND_PREP_FLUSH_EN is defined.
module fp_round_prep
   import fp_round_prep_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int EXP_W = DEF_EXP_W,
   parameter int STEP  = DEF_STEP,
   parameter int EMIN  = DEF_EMIN
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [IN_W-1:0]  io_in_sig,
   input  logic [EXP_W-1:0] io_in_exp,
   input  logic             io_in_sign,
   input  logic [2:0]       io_in_rm,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [OUT_W-1:0] io_out_sig,
   output logic             io_out_round,
   output logic             io_out_sticky,
   output logic [EXP_W-1:0] io_out_exp,
   output logic             io_out_sign,
   output logic [2:0]       io_out_rm
`ifdef FP_ROUND_PREP_FLUSH_EN
   ,
   input  logic             io_flush
`endif
);

   localparam int               LZC_W   = $clog2(IN_W + 1);
   localparam logic [EXP_W-1:0] EMIN_E  = EXP_W'(EMIN);
   localparam logic [EXP_W:0]   EMIN_X  = {EMIN_E[EXP_W-1], EMIN_E};
   localparam logic [EXP_W:0]   CLAMP_D = (EXP_W+1)'(IN_W + 1);

   state_t           state, state_n;
   logic [IN_W-1:0]  sig_q, sig_n;
   logic [EXP_W-1:0] exp_q, exp_n;
   logic             sticky_q, sticky_n;
   logic             sign_q, sign_n;
   logic [2:0]       rm_q, rm_n;

   logic [LZC_W-1:0] lzc;
   logic [EXP_W:0]   exp_x;
   logic [EXP_W:0]   span_l;
   logic [EXP_W:0]   span_r;
   int unsigned      k_l;
   int unsigned      k_r;
   logic [IN_W-1:0]  low_mask;

   fp_norm_lzc #(.IN_W(IN_W)) u_lzc (
      .value (sig_q),
      .count (lzc)
   );

   // Exponent differences are taken one bit wider so they never wrap.
   assign exp_x    = {exp_q[EXP_W-1], exp_q};
   assign span_l   = exp_x - EMIN_X;
   assign span_r   = EMIN_X - exp_x;
   assign k_l      = min3(32'(lzc), STEP, 32'(span_l));
   assign k_r      = (32'(span_r) < STEP) ? 32'(span_r) : STEP;
   assign low_mask = ~({IN_W{1'b1}} << k_r);

   always_comb begin
      state_n  = state;
      sig_n    = sig_q;
      exp_n    = exp_q;
      sticky_n = sticky_q;
      sign_n   = sign_q;
      rm_n     = rm_q;
      case (state)
         ST_IDLE: begin
            if (io_in_valid) begin
               sig_n    = io_in_sig;
               exp_n    = io_in_exp;
               sticky_n = 1'b0;
               sign_n   = io_in_sign;
               rm_n     = io_in_rm;
               state_n  = ($signed(io_in_exp) < $signed(EMIN_E)) ? ST_RSHIFT : ST_LSHIFT;
            end
         end
         ST_LSHIFT: begin
            if (sig_q[IN_W-1] || (sig_q == '0) || (exp_q == EMIN_E)) begin
               state_n = ST_DONE;
            end else begin
               sig_n = sig_q << k_l;
               exp_n = exp_q - EXP_W'(k_l);
            end
         end
         ST_RSHIFT: begin
            if (span_r == '0) begin
               state_n = ST_DONE;
            end else if (span_r > CLAMP_D) begin
               // Everything would fall off the bottom: collapse the whole shift into one cycle.
               sticky_n = sticky_q | (|sig_q);
               sig_n    = '0;
               exp_n    = EMIN_E;
            end else begin
               sticky_n = sticky_q | (|(sig_q & low_mask));
               sig_n    = sig_q >> k_r;
               exp_n    = exp_q + EXP_W'(k_r);
            end
         end
         ST_DONE: begin
            if (io_out_ready) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
`ifdef FP_ROUND_PREP_FLUSH_EN
      if (io_flush) begin
         state_n  = ST_IDLE;
         sig_n    = sig_q;
         exp_n    = exp_q;
         sticky_n = sticky_q;
         sign_n   = sign_q;
         rm_n     = rm_q;
      end
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         sig_q    <= '0;
         exp_q    <= '0;
         sticky_q <= 1'b0;
         sign_q   <= 1'b0;
         rm_q     <= '0;
      end else begin
         state    <= state_n;
         sig_q    <= sig_n;
         exp_q    <= exp_n;
         sticky_q <= sticky_n;
         sign_q   <= sign_n;
         rm_q     <= rm_n;
      end
   end

   assign io_in_ready   = (state == ST_IDLE);
   assign io_out_valid  = (state == ST_DONE);
   assign io_out_sig    = sig_q[IN_W-1 -: OUT_W];
   assign io_out_round  = sig_q[IN_W-OUT_W-1];
   assign io_out_sticky = sticky_q | (|sig_q[IN_W-OUT_W-2:0]);
   assign io_out_exp    = exp_q;
   assign io_out_sign   = sign_q;
   assign io_out_rm     = rm_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_round_prep.sv
`default_nettype none
// tb_fp_round_prep: scoreboard bench for fp_round_prep with directed, boundary and random operands.
module tb_fp_round_prep;

   localparam int IN_W  = 106;
   localparam int OUT_W = 53;
   localparam int EXP_W = 13;
   localparam int EMIN  = -1022;
   localparam int PK_W  = OUT_W + 2 + EXP_W + 4;

   typedef logic [PK_W-1:0] pk_t;
   typedef struct {
      pk_t res;
      int  lat;
   } exp_t;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             io_in_valid = 1'b0;
   logic             io_in_ready;
   logic [IN_W-1:0]  io_in_sig = '0;
   logic [EXP_W-1:0] io_in_exp = '0;
   logic             io_in_sign = 1'b0;
   logic [2:0]       io_in_rm = '0;
   logic             io_out_valid;
   logic             io_out_ready = 1'b0;
   logic [OUT_W-1:0] io_out_sig;
   logic             io_out_round;
   logic             io_out_sticky;
   logic [EXP_W-1:0] io_out_exp;
   logic             io_out_sign;
   logic [2:0]       io_out_rm;
`ifdef FP_ROUND_PREP_FLUSH_EN
   logic             io_flush = 1'b0;
`endif

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   fp_round_prep dut (
      .clock         (clock),
      .reset         (reset),
      .io_in_valid   (io_in_valid),
      .io_in_ready   (io_in_ready),
      .io_in_sig     (io_in_sig),
      .io_in_exp     (io_in_exp),
      .io_in_sign    (io_in_sign),
      .io_in_rm      (io_in_rm),
      .io_out_valid  (io_out_valid),
      .io_out_ready  (io_out_ready),
      .io_out_sig    (io_out_sig),
      .io_out_round  (io_out_round),
      .io_out_sticky (io_out_sticky),
      .io_out_exp    (io_out_exp),
      .io_out_sign   (io_out_sign),
      .io_out_rm     (io_out_rm)
`ifdef FP_ROUND_PREP_FLUSH_EN
      ,
      .io_flush      (io_flush)
`endif
   );

   always #5 clock = ~clock;

   function automatic pk_t pack(input logic [OUT_W-1:0] s, input logic r, input logic st,
                                input int e, input logic sg, input logic [2:0] rm);
      return {s, r, st, EXP_W'(e), sg, rm};
   endfunction

   function automatic pk_t observed();
      return {io_out_sig, io_out_round, io_out_sticky, io_out_exp, io_out_sign, io_out_rm};
   endfunction

   // Reference: exact shift to EMIN (right) or bit-at-a-time normalisation (left).
   function automatic pk_t model(input logic [IN_W-1:0] s, input int e, input logic sg,
                                 input logic [2:0] rm);
      logic [IN_W-1:0] v;
      logic            st;
      int              sh;
      v  = s;
      st = 1'b0;
      if (e < EMIN) begin
         sh = EMIN - e;
         for (int i = 0; i < IN_W; i++) if (i < sh && v[i]) st = 1'b1;
         v = (sh >= IN_W) ? '0 : (v >> sh);
         e = EMIN;
      end else if (v != '0) begin
         while (!v[IN_W-1] && e > EMIN) begin
            v = v << 1;
            e = e - 1;
         end
      end
      return {v[IN_W-1 -: OUT_W], v[IN_W-OUT_W-1], st | (|v[IN_W-OUT_W-2:0]), EXP_W'(e), sg, rm};
   endfunction

   task automatic issue(input logic [IN_W-1:0] s, input int e, input logic sg, input logic [2:0] rm);
      int guard;
      guard = 0;
      while (!io_in_ready && guard < 100) begin
         @(posedge clock); #1;
         guard++;
      end
      io_in_valid = 1'b1;
      io_in_sig   = s;
      io_in_exp   = EXP_W'(e);
      io_in_sign  = sg;
      io_in_rm    = rm;
      @(posedge clock); #1;
      io_in_valid = 1'b0;
   endtask

   task automatic collect(output pk_t obs, output int lat);
      lat = 0;
      while (!io_out_valid && lat < 300) begin
         @(posedge clock); #1;
         lat++;
      end
      obs = observed();
      if (io_out_valid) begin
         io_out_ready = 1'b1;
         @(posedge clock); #1;
         io_out_ready = 1'b0;
      end else begin
         lat = -1;
      end
   endtask

   task automatic push(input pk_t res, input int lat);
      exp_t x;
      x.res = res;
      x.lat = lat;
      sb.push_back(x);
   endtask

   task automatic test_reset;
      #1 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if ({io_in_ready, io_out_valid} !== 2'b10) begin
         n_bad++;
         $display("FAIL reset_handshake: ready/valid got %b want 10", {io_in_ready, io_out_valid});
      end
      n_cmp++;
      if (observed() !== '0) begin
         n_bad++;
         $display("FAIL reset_data: got %h want 0", observed());
      end
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_directed;
      logic [IN_W-1:0] sigs [8];
      int              exps [8];
      pk_t             res  [8];
      int              lats [8];
      pk_t             obs;
      int              lat;
      exp_t            x;
      sigs[0] = IN_W'(1);              exps[0] = 0;          lats[0] = 8;
      res[0]  = pack({1'b1, 52'b0}, 0, 0, -105, 1'b1, 3'd5);
      sigs[1] = {1'b1, 105'b0};        exps[1] = EMIN - 2;   lats[1] = 2;
      res[1]  = pack({2'b0, 1'b1, 50'b0}, 0, 0, EMIN, 1'b0, 3'd0);
      sigs[2] = {IN_W{1'b1}};          exps[2] = EMIN - 60;  lats[2] = 5;
      res[2]  = pack('0, 0, 1, EMIN, 1'b1, 3'd2);
      sigs[3] = IN_W'(3);              exps[3] = EMIN - 500; lats[3] = 2;
      res[3]  = pack('0, 0, 1, EMIN, 1'b0, 3'd7);
      sigs[4] = {1'b1, 52'b0, 1'b1, 51'b0, 1'b1}; exps[4] = 7; lats[4] = 1;
      res[4]  = pack({1'b1, 52'b0}, 1, 1, 7, 1'b1, 3'd4);
      sigs[5] = IN_W'(1);              exps[5] = EMIN + 3;   lats[5] = 2;
      res[5]  = pack('0, 0, 1, EMIN, 1'b0, 3'd1);
      sigs[6] = {IN_W{1'b1}};          exps[6] = EMIN - 107; lats[6] = 8;
      res[6]  = pack('0, 0, 1, EMIN, 1'b0, 3'd3);
      sigs[7] = {IN_W{1'b1}};          exps[7] = EMIN - 108; lats[7] = 2;
      res[7]  = pack('0, 0, 1, EMIN, 1'b1, 3'd6);
      for (int i = 0; i < 8; i++) begin
         push(res[i], lats[i]);
         issue(sigs[i], exps[i], res[i][3], res[i][2:0]);
         collect(obs, lat);
         x = sb.pop_front();
         n_cmp++;
         if (obs !== x.res) begin
            n_bad++;
            $display("FAIL directed_%0d result: got %h want %h", i, obs, x.res);
         end
         n_cmp++;
         if (lat !== x.lat) begin
            n_bad++;
            $display("FAIL directed_%0d latency: got %0d want %0d", i, lat, x.lat);
         end
      end
   endtask

   task automatic test_backpressure;
      pk_t  held;
      pk_t  obs;
      int   lat;
      exp_t x;
      push(pack({1'b1, 52'b0}, 0, 0, 0, 1'b0, 3'd1), 1);
      issue({1'b1, 105'b0}, 0, 1'b0, 3'd1);
      lat = 0;
      while (!io_out_valid && lat < 50) begin
         @(posedge clock); #1;
         lat++;
      end
      held = observed();
      x = sb.pop_front();
      n_cmp++;
      if (held !== x.res || lat !== x.lat) begin
         n_bad++;
         $display("FAIL stall_first: got %h lat %0d want %h lat %0d", held, lat, x.res, x.lat);
      end
      io_in_valid = 1'b1;
      io_in_sig   = '0;
      io_in_exp   = EXP_W'(5);
      io_in_sign  = 1'b1;
      io_in_rm    = 3'd6;
      for (int c = 0; c < 10; c++) begin
         @(posedge clock); #1;
         n_cmp++;
         if ({observed(), io_out_valid, io_in_ready} !== {held, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL stall_hold_%0d: got %h v%b r%b want %h v1 r0", c, observed(),
                     io_out_valid, io_in_ready, held);
         end
      end
      io_out_ready = 1'b1;
      @(posedge clock); #1;
      io_out_ready = 1'b0;
      n_cmp++;
      if ({io_in_ready, io_out_valid} !== 2'b10) begin
         n_bad++;
         $display("FAIL stall_release: ready/valid got %b want 10", {io_in_ready, io_out_valid});
      end
      push(pack('0, 0, 0, 5, 1'b1, 3'd6), 1);
      @(posedge clock); #1;
      io_in_valid = 1'b0;
      collect(obs, lat);
      x = sb.pop_front();
      n_cmp++;
      if (obs !== x.res || lat !== x.lat) begin
         n_bad++;
         $display("FAIL zero_input: got %h lat %0d want %h lat %0d", obs, lat, x.res, x.lat);
      end
   endtask

   task automatic test_random;
      logic [IN_W-1:0] s;
      int              e;
      logic            sg;
      logic [2:0]      rm;
      pk_t             obs;
      int              lat;
      exp_t            x;
      for (int i = 0; i < 12; i++) begin
         s  = IN_W'({$urandom, $urandom, $urandom, $urandom}) >> $urandom_range(0, IN_W);
         e  = EMIN - 150 + int'($urandom_range(0, 400));
         sg = 1'($urandom);
         rm = 3'($urandom);
         push(model(s, e, sg, rm), -1);
         issue(s, e, sg, rm);
         collect(obs, lat);
         x = sb.pop_front();
         n_cmp++;
         if (obs !== x.res || lat < 0) begin
            n_bad++;
            $display("FAIL random_%0d: sig %h exp %0d got %h lat %0d want %h", i, s, e, obs, lat, x.res);
         end
      end
   endtask

   task automatic test_reset_midop;
      bit rose;
      issue(IN_W'(1), 0, 1'b0, 3'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({io_in_ready, io_out_valid} !== 2'b10 || observed() !== '0) begin
         n_bad++;
         $display("FAIL reset_midop: ready/valid got %b data %h want 10 / 0",
                  {io_in_ready, io_out_valid}, observed());
      end
      @(posedge clock); #1;
      reset = 1'b1;
      rose = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clock); #1;
         if (io_out_valid) rose = 1'b1;
      end
      n_cmp++;
      if (rose !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_abort: out_valid rose got 1 want 0");
      end
   endtask

`ifdef FP_ROUND_PREP_FLUSH_EN
   task automatic test_flush;
      bit rose;
      issue(IN_W'(1), 0, 1'b0, 3'd0);
      io_flush = 1'b1;
      @(posedge clock); #1;
      io_flush = 1'b0;
      n_cmp++;
      if ({io_in_ready, io_out_valid} !== 2'b10) begin
         n_bad++;
         $display("FAIL flush_idle: ready/valid got %b want 10", {io_in_ready, io_out_valid});
      end
      rose = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clock); #1;
         if (io_out_valid) rose = 1'b1;
      end
      n_cmp++;
      if (rose !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_no_output: out_valid rose got 1 want 0");
      end
      io_in_valid = 1'b1;
      io_in_sig   = IN_W'(1);
      io_in_exp   = '0;
      io_flush    = 1'b1;
      @(posedge clock); #1;
      io_in_valid = 1'b0;
      io_flush    = 1'b0;
      n_cmp++;
      if (io_in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_dominates: in_ready got %b want 1", io_in_ready);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_random();
      test_reset_midop();
`ifdef FP_ROUND_PREP_FLUSH_EN
      test_flush();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/fp_round_prep.md
# fp_round_prep

Iterative normaliser that turns a wide, unnormalised floating-point significand into the `{mantissa, round, sticky}` triple consumed by the FPU's `RoundingUnit`. It sits between the wide datapath (multiplier/FMA product) and rounding. It left-normalises by leading-zero count, or right-shifts subnormals down to `EMIN`, collecting shifted-out bits into sticky. It uses a valid/ready handshake on both sides and holds one operation at a time.

## Interface
- `IN_W`, default 106: input significand width.
- `OUT_W`, default 53: output mantissa width; must satisfy `IN_W >= OUT_W + 2`.
- `EXP_W`, default 13: signed exponent width.
- `STEP`, default 16: maximum shift distance per cycle, in either direction.
- `EMIN`, default -1022: minimum exponent; left shifts never go below it, right shifts raise to it.
- Clocking: one clock; reset is asynchronous and active-low.
- `clock`  input  1  clock.
- `reset`  input  1  asynchronous, active-low reset.
- `io_in_valid`  input  1  operand valid.
- `io_in_ready`  output  1  high only in IDLE.
- `io_in_sig`  input  IN_W  significand; value = sig × 2^exp, MSB at bit IN_W-1.
- `io_in_exp`  input  EXP_W  signed exponent.
- `io_in_sign`  input  1  sign, passed through.
- `io_in_rm`  input  3  rounding mode, passed through.
- `io_out_valid`  output  1  result valid.
- `io_out_ready`  input  1  consumer accepts.
- `io_out_sig`  output  OUT_W  `sig_q[IN_W-1 -: OUT_W]`.
- `io_out_round`  output  1  `sig_q[IN_W-OUT_W-1]`.
- `io_out_sticky`  output  1  `sticky_q | (|sig_q[IN_W-OUT_W-2:0])`.
- `io_out_exp`  output  EXP_W  final exponent.
- `io_out_sign`  output  1  registered sign.
- `io_out_rm`  output  3  registered rounding mode.
- `io_flush`  input  1  kill the in-flight operation. Present only with `FP_ROUND_PREP_FLUSH_EN`.

## Operation
- The state machine has four states: IDLE, LSHIFT, RSHIFT and DONE.
- Registered state: `sig_q`, `exp_q`, `sticky_q`, `sign_q`, `rm_q`.
- IDLE:
  - On `io_in_valid`, load all registers and clear `sticky_q`.
  - Go to RSHIFT if `io_in_exp < EMIN`, otherwise go to LSHIFT.
- LSHIFT:
  - If `sig_q[IN_W-1]`, or `sig_q == 0`, or `exp_q == EMIN`, go to DONE with no shift.
  - Otherwise compute `k = min(lzc(sig_q), STEP, exp_q - EMIN)`, then apply `sig_q <<= k` and `exp_q -= k`.
- RSHIFT: let `d = EMIN - exp_q` (unsigned, computed at EXP_W+1 bits).
  - If `d == 0`, go to DONE.
  - Else if `d > IN_W + 1`: `sticky_q |= |sig_q`, `sig_q = 0`, `exp_q = EMIN`, all in one cycle.
  - Else `k = min(d, STEP)`: `sticky_q |= |sig_q[k-1:0]`, `sig_q >>= k`, `exp_q += k`.
- DONE:
  - `io_out_valid = 1`.
  - On `io_out_ready`, go to IDLE.
  - Outputs stay stable while stalled.
- Zero input (LSHIFT): result is sig 0, round 0, sticky 0, and the input exponent unchanged.
- Exponent arithmetic never wraps. `exp_q` stays within `[EMIN, input exponent]`.

## Timing
- `io_in_ready = (state == IDLE)`, combinational from state. There is no same-cycle bypass from DONE to accept.
- Latency: with N shifting cycles, `io_out_valid` rises N+1 edges after the acceptance edge. An already-normalised input takes 1 edge.
- Throughput: one operation at a time. The next operation is accepted at the earliest one cycle after the output handshake.
- Reset values:
  - State is IDLE, so `io_in_ready = 1`.
  - `io_out_valid = 0`.
  - All data registers are 0, so every data output reads 0.
- Reset mid-operation aborts immediately; no output is produced.

## Configuration
- `FP_ROUND_PREP_FLUSH_EN` defined:
  - The `io_flush` port exists.
  - Flush forces IDLE at the next edge from any state and drops `io_out_valid` there.
  - Flush dominates an input handshake in the same cycle; that operand is not accepted.
- `FP_ROUND_PREP_FLUSH_EN` undefined: the port is absent and there is no flush logic.

## Structure
- The shared package `fp_round_prep_pkg` holds:
  - the state enum (IDLE/LSHIFT/RSHIFT/DONE);
  - default width constants;
  - a `min3` helper function.
- One sub-module, `fp_norm_lzc`: a parameterised IN_W leading-zero counter. Its output is `$clog2(IN_W+1)` bits wide and equals IN_W for a zero input.

## Test plan
- `sig = 1`, `exp = 0`:
  - Shifts run 16×6 then 9, so N = 7.
  - `io_out_valid` rises 8 edges after acceptance.
  - Outputs: `out_sig = 1<<52`, exp = -105, round = 0, sticky = 0.
- `sig = 1<<105`, `exp = EMIN-2`: one right shift, `out_sig = 1<<50`, exp = EMIN, round = 0, sticky = 0, latency 2.
- `sig` all ones, `exp = EMIN-60`:
  - Shifts run 16, 16, 16, 12, so latency is 5.
  - Outputs: `out_sig = 0`, round = 0, sticky = 1.
- `sig = 3`, `exp = EMIN-500`: clamp in one cycle, `out_sig = 0`, sticky = 1, exp = EMIN.
- Backpressure:
  - Hold `io_out_ready = 0` for 10 cycles. Outputs stay constant, and `io_in_ready = 0` while `io_in_valid = 1`.
  - Zero input `sig = 0`, `exp = 5` then gives outputs 0 with exp 5.
- Flush (macro on): assert `io_flush` during LSHIFT. At the next edge the block is in IDLE, `io_in_ready = 1` and `io_out_valid` never rises.
